// File: rtl/div_pkg.sv
// Shared definitions for the divider sequencer: FSM state encoding and default quotient width.
package div_pkg;

  localparam int unsigned DIV_N = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_OVCHK  = 3'd2,
    S_SHIFT  = 3'd3,
    S_CMP    = 3'd4,
    S_FINISH = 3'd5
  } div_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: the pointer picks the winner only when both inputs request.
module rr_arb2 (
  input  logic [1:0] REQ,
  input  logic       PTR,
  output logic [1:0] GNT
);

  always_comb begin
    GNT = REQ;
    if (REQ == 2'b11) begin
      GNT = PTR ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/div_arb_sequencer.sv
// Arbitrates two requesters onto a shared shift/subtract divider and sequences
// its load, overflow check and N shift/compare iterations.
module div_arb_sequencer
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] REQ,
  input  logic       C,
  output logic       SEL,
  output logic       Ld,
  output logic       Sh,
  output logic       Su,
  output logic       V,
  output logic [1:0] ACK,
  output logic       BUSY
);

  localparam int unsigned CW = $clog2(N + 1);

  div_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_gnt;
  logic          r_ptr;
  logic          r_v;
  logic          r_ld;
  logic          r_sh;
  logic          r_cmp;
  logic          r_busy;
  logic [1:0]    r_ack;
  logic [1:0]    w_gnt;
  logic          w_last;

  rr_arb2 u_arb (
    .REQ (REQ),
    .PTR (r_ptr),
    .GNT (w_gnt)
  );

  assign w_last = (r_cnt == CW'(N));

  // Owner is kept as the latched one-hot grant, so ACK is a copy of it and
  // SEL is its upper bit; outputs are registered on entry to each state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_gnt   <= 2'b01;
      r_ptr   <= 1'b0;
      r_v     <= 1'b0;
      r_ld    <= 1'b0;
      r_sh    <= 1'b0;
      r_cmp   <= 1'b0;
      r_busy  <= 1'b0;
      r_ack   <= '0;
    end else begin
      r_ld  <= 1'b0;
      r_sh  <= 1'b0;
      r_cmp <= 1'b0;
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (|REQ) begin
            r_gnt   <= w_gnt;
            r_ld    <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_cnt   <= '0;
          r_v     <= 1'b0;
          r_state <= S_OVCHK;
        end
        S_OVCHK: begin
          if (C) begin
            r_v     <= 1'b1;
            r_ack   <= r_gnt;
            r_state <= S_FINISH;
          end else begin
            r_sh    <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_cnt   <= r_cnt + CW'(1);
          r_cmp   <= 1'b1;
          r_state <= S_CMP;
        end
        S_CMP: begin
          if (w_last) begin
            r_ack   <= r_gnt;
            r_state <= S_FINISH;
          end else begin
            r_sh    <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_FINISH: begin
          r_ptr   <= r_gnt[0];
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign SEL  = r_gnt[1];
  assign Ld   = r_ld;
  assign Sh   = r_sh;
  assign Su   = r_cmp & C;
  assign V    = r_v;
  assign ACK  = r_ack;
  assign BUSY = r_busy;

endmodule

// File: tb/tb_div_arb_sequencer.sv
// Bench for div_arb_sequencer with a behavioural shift/subtract datapath and an ACK-driven scoreboard.
module tb_div_arb_sequencer;
  import div_pkg::*;

  localparam int unsigned N = DIV_N;

  typedef struct {
    logic [1:0]     req;
    logic [2*N-1:0] dvd;
    logic [N-1:0]   dvs;
    logic [1:0]     ack;
    logic           v;
    logic [N-1:0]   q;
    logic [N-1:0]   r;
  } vec_t;

  typedef struct {
    logic [1:0]   ack;
    logic         v;
    logic [N-1:0] q;
    logic [N-1:0] r;
    int unsigned  lat;
    int unsigned  nsh;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] REQ = 2'b00;
  logic       C;
  logic       SEL, Ld, Sh, Su, V, BUSY;
  logic [1:0] ACK;

  logic [2*N-1:0] opd0 = '0, opd1 = '0;
  logic [N-1:0]   ops0 = '1, ops1 = '1;
  logic [2*N:0]   x = '0;
  logic [N-1:0]   dvs = '1;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned illegal = 0;
  int unsigned cyc = 0;
  int unsigned ld_cyc = 0;
  int unsigned sh_cnt = 0;
  logic [1:0]  prev_ack = 2'b00;
  exp_t        sb[$];
  vec_t        vt[6];

  div_arb_sequencer #(.N(N)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .REQ  (REQ),
    .C    (C),
    .SEL  (SEL),
    .Ld   (Ld),
    .Sh   (Sh),
    .Su   (Su),
    .V    (V),
    .ACK  (ACK),
    .BUSY (BUSY)
  );

  always #5 CLK = ~CLK;

  // Restoring divider: upper N+1 bits compared against the divisor.
  assign C = (x[2*N:N] >= {1'b0, dvs});

  always @(posedge CLK) begin
    if (Ld) begin
      x   <= {1'b0, (SEL ? opd1 : opd0)};
      dvs <= SEL ? ops1 : ops0;
    end else if (Sh) begin
      x <= x << 1;
    end else if (Su) begin
      x[2*N:N] <= x[2*N:N] - {1'b0, dvs};
      x[0]     <= 1'b1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] a, input logic v, input logic [N-1:0] q, input logic [N-1:0] r);
    exp_t e;
    e.ack = a;
    e.v   = v;
    e.q   = q;
    e.r   = r;
    e.lat = v ? 2 : 2 * N + 2;
    e.nsh = v ? 0 : N;
    sb.push_back(e);
  endtask

  task automatic wait_ack(input bit drop);
    int unsigned k;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (ACK == 2'b00 && k < 100);
    if (ACK == 2'b00) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: no ACK within %0d cycles", k);
    end else if (drop) begin
      REQ = REQ & ~ACK;
    end
  endtask

  // Scoreboard side: every ACK pops one expected completion.
  always @(negedge CLK) begin
    exp_t e;
    cyc++;
    if (!BUSY && (Ld || Sh || Su)) illegal++;
    if (ACK != 2'b00 && prev_ack != 2'b00) illegal++;
    if (ACK == 2'b11) illegal++;
    prev_ack = ACK;
    if (Ld) begin
      ld_cyc = cyc;
      sh_cnt = 0;
    end
    if (Sh) sh_cnt++;
    if (ACK != 2'b00) begin
      if (sb.size() == 0) begin
        check("ack_unexpected", {30'd0, ACK}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_owner", {30'd0, ACK}, {30'd0, e.ack});
        check("v_flag", {31'd0, V}, {31'd0, e.v});
        check("ack_latency", cyc - ld_cyc, e.lat);
        check("sh_pulses", sh_cnt, e.nsh);
        if (!e.v) begin
          check("quotient", {{(32-N){1'b0}}, x[N-1:0]}, {{(32-N){1'b0}}, e.q});
          check("remainder", {{(32-N){1'b0}}, x[2*N-1:N]}, {{(32-N){1'b0}}, e.r});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    vt[0] = '{2'b01, 8'd135, 4'd13, 2'b01, 1'b0, 4'd10, 4'd5};
    vt[1] = '{2'b10, 8'd200, 4'd5,  2'b10, 1'b1, 4'd0,  4'd0};
    vt[2] = '{2'b01, 8'd15,  4'd1,  2'b01, 1'b0, 4'd15, 4'd0};
    vt[3] = '{2'b10, 8'd100, 4'd7,  2'b10, 1'b0, 4'd14, 4'd2};
    vt[4] = '{2'b01, 8'd112, 4'd7,  2'b01, 1'b1, 4'd0,  4'd0};
    vt[5] = '{2'b10, 8'd0,   4'd3,  2'b10, 1'b0, 4'd0,  4'd0};

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("reset_outputs", {25'd0, SEL, Ld, Sh, Su, V, BUSY, ACK}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (vt[i].req[1]) begin
        opd1 = vt[i].dvd;
        ops1 = vt[i].dvs;
      end else begin
        opd0 = vt[i].dvd;
        ops0 = vt[i].dvs;
      end
      REQ = vt[i].req;
      push(vt[i].ack, vt[i].v, vt[i].q, vt[i].r);
      @(negedge CLK);
      check("load_next_cycle", {29'd0, Ld, SEL, BUSY}, {29'd0, 1'b1, vt[i].req[1], 1'b1});
      wait_ack(1'b1);
    end

    // Both requesting from reset: 0 first, then 1, then alternation via the pointer.
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST  = 1'b0;
    opd0 = 8'd15;  ops0 = 4'd1;
    opd1 = 8'd100; ops1 = 4'd7;
    REQ  = 2'b11;
    push(2'b01, 1'b0, 4'd15, 4'd0);
    push(2'b10, 1'b0, 4'd14, 4'd2);
    wait_ack(1'b1);
    wait_ack(1'b1);
    @(negedge CLK);
    REQ = 2'b11;
    push(2'b01, 1'b0, 4'd15, 4'd0);
    push(2'b10, 1'b0, 4'd14, 4'd2);
    wait_ack(1'b1);
    wait_ack(1'b1);
    @(negedge CLK);
    REQ = 2'b01;
    push(2'b01, 1'b0, 4'd15, 4'd0);
    wait_ack(1'b1);
    @(negedge CLK);
    REQ = 2'b11;
    push(2'b10, 1'b0, 4'd14, 4'd2);
    push(2'b01, 1'b0, 4'd15, 4'd0);
    wait_ack(1'b1);
    wait_ack(1'b1);

    // Reset during the third SHIFT aborts silently; the held request is re-served.
    @(negedge CLK);
    opd0 = 8'd135; ops0 = 4'd13;
    REQ  = 2'b01;
    push(2'b01, 1'b0, 4'd10, 4'd5);
    n = 0;
    for (int k = 0; k < 50 && n < 3; k++) begin
      @(negedge CLK);
      if (Sh) n++;
    end
    check("third_shift_reached", n, 32'd3);
    RST = 1'b1;
    @(negedge CLK);
    check("abort_idle", {26'd0, BUSY, V, Ld, Sh, ACK}, 32'd0);
    RST = 1'b0;
    wait_ack(1'b1);

    // REQ held one cycle past ACK starts a second operation.
    @(negedge CLK);
    opd0 = 8'd100; ops0 = 4'd7;
    REQ  = 2'b01;
    push(2'b01, 1'b0, 4'd14, 4'd2);
    push(2'b01, 1'b0, 4'd14, 4'd2);
    wait_ack(1'b0);
    @(negedge CLK);
    check("idle_after_ack", {29'd0, BUSY, Ld, Sh}, 32'd0);
    @(negedge CLK);
    check("second_load", {30'd0, Ld, BUSY}, 32'd3);
    wait_ack(1'b1);

    repeat (5) @(negedge CLK);
    check("scoreboard_drained", sb.size(), 32'd0);
    check("no_illegal_outputs", illegal, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_arb_sequencer.md
Name: div_arb_sequencer

Overview:
Sequences a shared shift/subtract divider datapath of N-bit quotient width on behalf of two requesters. Two-way round-robin arbitration, a load/overflow-check/shift-subtract loop, and a one-cycle completion acknowledge to the owning requester. Sits between the requesting units and the divider datapath: drives operand select, Ld, Sh and Su; consumes the datapath comparator output C.

Parameters:
N, 4, quotient width = number of shift/compare iterations; legal N >= 2.
CW, $clog2(N+1), iteration counter width (derived; not overridden).

Ports:
CLK  input  1  rising-edge clock
RST  input  1  synchronous, active-high reset
REQ  input  2  level request per requester; held high until matching ACK bit
C    input  1  datapath compare: upper dividend >= divisor
SEL  output 1  operand mux select = current owner index
Ld   output 1  load dividend/divisor from the SEL requester
Sh   output 1  shift dividend register left one bit
Su   output 1  subtract divisor from upper half; set quotient LSB
V    output 1  overflow flag for the last completed operation
ACK  output 2  one-cycle completion pulse, one-hot to owner
BUSY output 1  high in every state except IDLE

Behaviour:
- Reset (RST=1 at a CLK edge): state=IDLE, counter=0, owner=0, rr pointer=0, V=0. Ld=Sh=Su=0, ACK=0, BUSY=0, SEL=0. Reset mid-operation aborts with no ACK; the requester keeps REQ high and is re-served.
- States: IDLE, LOAD, OVCHK, SHIFT, CMP, FINISH. Registered state. Outputs decoded from state; Su additionally gated by C (Mealy).
- IDLE: if REQ!=0, grant via round-robin, latch owner, go to LOAD. Both requesting: requester at rr pointer wins. One requesting: it wins regardless of pointer.
- LOAD: Ld=1, SEL=owner, counter<=0, V<=0; go to OVCHK.
- OVCHK: sample C. C=1: V<=1, go to FINISH (overflow; no shifts). C=0: go to SHIFT.
- SHIFT: Sh=1, counter<=counter+1; go to CMP.
- CMP: Su=C. If counter==N go to FINISH, else go to SHIFT.
- FINISH: ACK[owner]=1 for exactly one cycle; rr pointer<=~owner; go to IDLE.
- SEL holds the owner value from LOAD through FINISH. It holds its last value in IDLE.
- V holds from FINISH until the next LOAD, so the requester may sample it with ACK.
- Latency: REQ sampled in IDLE at cycle t. LOAD at t+1. Normal ACK at t+2N+3. Overflow ACK at t+3. Exactly N Sh pulses per non-overflow operation.
- The requester must drop REQ in the cycle after ACK. REQ still high when IDLE is re-entered counts as a new request.
- REQ changes while BUSY are ignored until IDLE. A non-owner REQ stays pending.
- Counter never wraps: it is bounded by N and cleared in LOAD.

Decomposition:
- Shared package div_pkg: state encoding localparams (IDLE..FINISH) and default quotient width DIV_N=4, both reused by datapath and bench.
- One sub-module, rr_arb2: 2-input round-robin arbiter. Ports REQ[1:0], pointer in, one-hot grant out; combinational. Pointer register stays in the sequencer.

Test Plan:
- N=4, behavioural datapath. REQ=01, dividend 135, divisor 13 -> Ld at t+1; 4 Sh pulses; Su in CMP cycles matching quotient 1010; ACK=01 at t+11; V=0; datapath quotient 10, remainder 5.
- REQ=10, dividend 200, divisor 5 (upper nibble 12 >= 5) -> C=1 in OVCHK, no Sh, V=1 and ACK=10 at t+3.
- REQ=11 from reset -> requester 0 served first (ACK=01). Requester 1 is granted in the next IDLE cycle (ACK=10). With both held again, requester 0 is served next (alternation).
- RST asserted during the third SHIFT -> next cycle IDLE: BUSY=0, V=0, ACK=00. Held REQ=01 is re-served from LOAD and completes normally.
- REQ=01 held high one cycle past ACK -> second operation starts. Each operation yields exactly one ACK pulse; no Ld/Sh/Su asserts while in IDLE.
- Dividend 15, divisor 1 (largest non-overflow quotient 15) -> Su in all 4 CMP cycles, V=0, ACK at t+11.
